// File: rtl/data_bus_router.sv
// data_bus_router: address-decoding router between the core data port and
// the data-side slaves. It allows one outstanding transaction at a time and
// generates local error responses for unmapped addresses and slave timeouts.
module data_bus_router #(
  parameter int                       N_SLAVES       = 2,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE     = {32'h0010_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK     = {32'hFFFF_E000, 32'hFFFF_E000},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     core_req_i,
  input  logic [31:0]              core_addr_i,
  input  logic                     core_we_i,
  input  logic [3:0]               core_be_i,
  input  logic [31:0]              core_wdata_i,
  output logic                     core_gnt_o,
  output logic                     core_rvalid_o,
  output logic [31:0]              core_rdata_o,
  output logic                     core_err_o,
  output logic [N_SLAVES-1:0]      s_req_o,
  output logic [31:0]              s_addr_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_wdata_o,
  input  logic [N_SLAVES-1:0]      s_gnt_i,
  input  logic [N_SLAVES-1:0]      s_rvalid_i,
  input  logic [N_SLAVES*32-1:0]   s_rdata_i,
  output logic [7:0]               err_count_o
);

  localparam int          SW       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [SW-1:0]        r_sel;
  logic [15:0]          r_cnt;
  logic [7:0]           r_err_count;

  logic [N_SLAVES-1:0]  w_match;
  logic                 w_hit;
  logic [SW-1:0]        w_sel;
  logic [31:0]          w_rdata [N_SLAVES];
  logic                 w_take;      // transaction granted: latch slave, clear counter
  logic                 w_err_resp;  // an error response is presented this cycle

  // Request fields are broadcast; only s_req_o is steered.
  assign s_addr_o    = core_addr_i;
  assign s_we_o      = core_we_i;
  assign s_be_o      = core_be_i;
  assign s_wdata_o   = core_wdata_i;
  assign err_count_o = r_err_count;

  // Per-slave address match and unpacked view of the read data bus.
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
    assign w_match[gi] = (core_addr_i & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
    assign w_rdata[gi] = s_rdata_i[32*gi +: 32];
  end

  // Priority decode: the lowest-index matching slave wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
    end
  end

  // Next-state and output logic; outputs are held quiet while reset is asserted
  // so a dropped transaction never produces a response.
  always_comb begin
    w_state_next  = r_state;
    w_take        = 1'b0;
    w_err_resp    = 1'b0;
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    core_err_o    = 1'b0;
    s_req_o       = '0;
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          if (core_req_i) begin
            if (w_hit) begin
              s_req_o[w_sel] = 1'b1;
              core_gnt_o     = s_gnt_i[w_sel];
              if (s_gnt_i[w_sel]) begin
                w_take = 1'b1;
                // A slave answering in its grant cycle completes without WAIT.
                if (s_rvalid_i[w_sel]) begin
                  core_rvalid_o = 1'b1;
                  core_rdata_o  = w_rdata[w_sel];
                end else begin
                  w_state_next = ST_WAIT;
                end
              end
            end else begin
              core_gnt_o   = 1'b1;
              w_state_next = ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          // A real response takes priority over a timeout in the same cycle.
          if (s_rvalid_i[r_sel]) begin
            core_rvalid_o = 1'b1;
            core_rdata_o  = w_rdata[r_sel];
            w_state_next  = ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            core_rvalid_o = 1'b1;
            core_err_o    = 1'b1;
            core_rdata_o  = ERR_RDATA;
            w_err_resp    = 1'b1;
            w_state_next  = ST_IDLE;
          end
        end
        ST_ERR: begin
          core_rvalid_o = 1'b1;
          core_err_o    = 1'b1;
          core_rdata_o  = ERR_RDATA;
          w_err_resp    = 1'b1;
          w_state_next  = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Selected-slave latch and wait-cycle counter for the timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_sel <= w_sel;
      r_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Saturating count of error responses delivered to the core.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_count <= '0;
    end else if (w_err_resp && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_data_bus_router.sv
// Testbench for data_bus_router: table vectors, directed multi-cycle
// sequences and a randomized run against a transaction-level model.
module tb_data_bus_router;

  localparam int          TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic [31:0] core_addr_i;
  logic        core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic [1:0]  s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic [1:0]  s_gnt_i;
  logic [1:0]  s_rvalid_i;
  logic [63:0] s_rdata_i;
  logic [7:0]  err_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  data_bus_router #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic quiet();
    rst_i = 1'b0; core_req_i = 1'b0; core_addr_i = '0; core_we_i = 1'b0;
    core_be_i = 4'hF; core_wdata_i = '0; s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic we);
    core_req_i = 1'b1; core_addr_i = a; core_we_i = we; core_wdata_i = a ^ 32'h5555_0000;
  endtask

  // ---------------- table-driven single-cycle vectors (all leave IDLE) -----
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        exp_gnt;
    logic        exp_rv;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_sreq;
  } vec_t;

  vec_t vecs[6];

  // ---------------- behavioural reference model for random phase ----------
  int m_busy;   // slave with an outstanding transaction, -1 when none
  bit m_errp;   // local error response owed next cycle
  int m_wait;   // cycles spent waiting on m_busy
  int m_errs;   // error responses delivered, saturating

  function automatic int decode(input logic [31:0] a);
    logic [31:0] base [2];
    logic [31:0] mask [2];
    base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_E000;
    base[1] = 32'h0010_0000; mask[1] = 32'hFFFF_E000;
    for (int i = 0; i < 2; i++)
      if ((a & mask[i]) == base[i]) return i;
    return -1;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_eval(output logic [63:0] exp);
    logic g, rv, er;
    logic [31:0] rd;
    logic [1:0] sr;
    int t;
    int cnt_now;
    g = 0; rv = 0; er = 0; rd = '0; sr = '0;
    cnt_now = m_errs;
    if (!rst_i) begin
      if (m_errp) begin
        rv = 1; er = 1; rd = ERR_VAL; m_errp = 0; m_errs = sat_inc(m_errs);
      end else if (m_busy >= 0) begin
        m_wait++;
        if (s_rvalid_i[m_busy]) begin
          rv = 1; rd = s_rdata_i[32*m_busy +: 32]; m_busy = -1;
        end else if (m_wait == TO) begin
          rv = 1; er = 1; rd = ERR_VAL; m_busy = -1; m_errs = sat_inc(m_errs);
        end
      end else if (core_req_i) begin
        t = decode(core_addr_i);
        if (t < 0) begin
          g = 1; m_errp = 1;
        end else begin
          sr[t] = 1'b1;
          if (s_gnt_i[t]) begin
            g = 1;
            if (s_rvalid_i[t]) begin
              rv = 1; rd = s_rdata_i[32*t +: 32];
            end else begin
              m_busy = t; m_wait = 0;
            end
          end
        end
      end
    end else begin
      m_busy = -1; m_errp = 0; m_wait = 0; m_errs = 0;
    end
    exp = {19'd0, g, rv, er, rd, sr, cnt_now[7:0]};
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] off;
    int cls;

    vecs[0] = '{1'b0, 32'h0000_0010, 2'b11, 2'b11, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 2'b00};
    vecs[1] = '{1'b1, 32'h0000_0000, 2'b00, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 2'b01};
    vecs[2] = '{1'b1, 32'h0000_1FFC, 2'b01, 2'b01, 32'hA5A5_0001, 32'h2, 1'b1, 1'b1, 32'hA5A5_0001, 2'b01};
    vecs[3] = '{1'b1, 32'h0010_1FFF, 2'b10, 2'b10, 32'h1, 32'h5A5A_0002, 1'b1, 1'b1, 32'h5A5A_0002, 2'b10};
    vecs[4] = '{1'b1, 32'h0010_0000, 2'b01, 2'b01, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 2'b10};
    vecs[5] = '{1'b1, 32'h0000_0100, 2'b01, 2'b11, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1, 32'h1111_2222, 2'b01};

    quiet();
    rst_i = 1'b1;
    tick();
    settle();
    check("reset_outputs", {core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o, s_req_o, err_count_o},
          64'd0);
    tick();
    rst_i = 1'b0;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      quiet();
      core_req_i = vecs[i].req; core_addr_i = vecs[i].addr;
      s_gnt_i = vecs[i].gnt; s_rvalid_i = vecs[i].rv;
      s_rdata_i = {vecs[i].rd1, vecs[i].rd0};
      settle();
      check($sformatf("vec%0d", i),
            {core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o, s_req_o},
            {vecs[i].exp_gnt, vecs[i].exp_rv, 1'b0, vecs[i].exp_rdata, vecs[i].exp_sreq});
      if (i == 5) check("addr_broadcast", s_addr_o, vecs[i].addr);
      tick();
    end

    // Read to slave 0 with a two-cycle response
    quiet(); req(32'h0000_0010, 1'b0); s_gnt_i = 2'b01;
    settle();
    check("rd_grant", {core_gnt_o, core_rvalid_o, s_req_o}, {1'b1, 1'b0, 2'b01});
    tick();
    quiet(); settle();
    check("rd_wait", {core_gnt_o, core_rvalid_o, s_req_o}, 4'b0000);
    tick();
    quiet(); s_rvalid_i = 2'b01; s_rdata_i = {32'h0, 32'h1234_5678};
    settle();
    check("rd_resp", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b0, 32'h1234_5678});
    tick();

    // Same-cycle grant and response from slave 1, then back-to-back
    quiet(); req(32'h0010_0004, 1'b1); s_gnt_i = 2'b10; s_rvalid_i = 2'b10;
    s_rdata_i = {32'hCAFE_0001, 32'h0};
    settle();
    check("fast_first", {core_gnt_o, core_rvalid_o, core_rdata_o, s_req_o},
          {1'b1, 1'b1, 32'hCAFE_0001, 2'b10});
    tick();
    req(32'h0010_0008, 1'b0); s_rdata_i = {32'h0BAD_0002, 32'h0};
    settle();
    check("fast_b2b", {core_gnt_o, core_rvalid_o, core_rdata_o}, {1'b1, 1'b1, 32'h0BAD_0002});
    tick();

    // Unmapped access
    quiet(); req(32'h8000_0000, 1'b0);
    settle();
    check("unmap_gnt", {core_gnt_o, core_rvalid_o, s_req_o}, {1'b1, 1'b0, 2'b00});
    tick();
    quiet(); settle();
    check("unmap_err", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b1, ERR_VAL});
    tick();
    settle();
    check("unmap_cnt", err_count_o, 8'd1);
    tick();

    // Timeout: grant, no response, error exactly TO cycles after the grant
    quiet(); req(32'h0000_0020, 1'b0); s_gnt_i = 2'b01;
    settle(); tick();
    quiet();
    for (int k = 1; k < TO; k++) begin
      settle();
      check($sformatf("to_quiet%0d", k), core_rvalid_o, 1'b0);
      tick();
    end
    settle();
    check("to_err", {core_rvalid_o, core_err_o, core_rdata_o}, {1'b1, 1'b1, ERR_VAL});
    tick();
    s_rvalid_i = 2'b01; s_rdata_i = {32'h0, 32'h7777_7777};
    settle();
    check("to_stray", {core_rvalid_o, err_count_o}, {1'b0, 8'd2});
    tick();

    // Request held during WAIT is blocked, then granted after the response
    quiet(); req(32'h0000_0030, 1'b0); s_gnt_i = 2'b01;
    settle(); tick();
    req(32'h0010_0000, 1'b0); s_gnt_i = 2'b10;
    for (int k = 0; k < 2; k++) begin
      settle();
      check($sformatf("hold_block%0d", k), {core_gnt_o, s_req_o}, 3'b000);
      tick();
    end
    s_rvalid_i = 2'b01; s_rdata_i = {32'h0, 32'h0000_55AA};
    settle();
    check("hold_resp", {core_gnt_o, core_rvalid_o, core_rdata_o}, {1'b0, 1'b1, 32'h0000_55AA});
    tick();
    s_rvalid_i = 2'b00;
    settle();
    check("hold_grant", {core_gnt_o, s_req_o}, {1'b1, 2'b10});
    tick();
    core_req_i = 1'b0; s_gnt_i = 2'b00; s_rvalid_i = 2'b10; s_rdata_i = {32'h4242_4242, 32'h0};
    settle();
    check("hold_resp2", {core_rvalid_o, core_rdata_o}, {1'b1, 32'h4242_4242});
    tick();

    // Reset in WAIT drops the transaction
    quiet(); req(32'h0000_0040, 1'b0); s_gnt_i = 2'b01;
    settle(); tick();
    quiet(); settle(); tick();
    rst_i = 1'b1;
    settle();
    check("rst_wait_rv", core_rvalid_o, 1'b0);
    tick();
    rst_i = 1'b0; s_rvalid_i = 2'b01; s_rdata_i = {32'h0, 32'h9999_9999};
    settle();
    check("rst_after", {core_rvalid_o, err_count_o}, {1'b0, 8'd0});
    tick();

    // 300 unmapped accesses saturate the error counter
    quiet(); req(32'hF000_0000, 1'b0);
    for (int k = 0; k < 600; k++) tick();
    quiet(); settle(); tick();
    settle();
    check("err_sat", err_count_o, 8'd255);
    tick();

    // Randomized run against the reference model
    do_reset();
    m_busy = -1; m_errp = 0; m_wait = 0; m_errs = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      core_req_i = ($urandom_range(0, 3) != 0);
      cls = $urandom_range(0, 2);
      off = $urandom & 32'h0000_1FFF;
      case (cls)
        0: core_addr_i = off;
        1: core_addr_i = 32'h0010_0000 | off;
        default: core_addr_i = ($urandom & 32'hFFFF_0000) | 32'h0000_2000 | off;
      endcase
      core_we_i = 1'($urandom);
      core_be_i = 4'($urandom);
      core_wdata_i = $urandom;
      s_gnt_i = 2'($urandom);
      s_rvalid_i = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      s_rdata_i = {$urandom, $urandom};
      model_eval(exp);
      settle();
      check($sformatf("rand%0d", c),
            {19'd0, core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o, s_req_o, err_count_o}, exp);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Address-decoding router between the CV32E40P core data port and the SoC data-side slaves (data memory, peripheral bridge, and so on). It forwards each core request to exactly one slave, selected by a base/mask match, and tracks the single outstanding transaction. It returns that slave's response to the core. Unmapped addresses and unresponsive slaves get a local error response.

## Interface
Parameters:
- N_SLAVES, 2, number of routed slaves (1..8).
- SLAVE_BASE, {32'h0010_0000, 32'h0000_0000}, packed N_SLAVES×32 base addresses; index i occupies bits [32i+31:32i].
- SLAVE_MASK, {32'hFFFF_E000, 32'hFFFF_E000}, packed N_SLAVES×32 masks; slave i matches when (addr & MASK[i]) == BASE[i].
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a timeout error; legal range 1..65535.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on any error response.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- core_req_i  in  1  core data request.
- core_addr_i  in  32  byte address.
- core_we_i  in  1  write enable.
- core_be_i  in  4  byte enables.
- core_wdata_i  in  32  write data.
- core_gnt_o  out  1  grant to the core.
- core_rvalid_o  out  1  response valid to the core.
- core_rdata_o  out  32  read data to the core.
- core_err_o  out  1  error flag, qualified by core_rvalid_o.
- s_req_o  out  N_SLAVES  one-hot request to the slaves.
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  32/1/4/32  broadcast copies of the core fields.
- s_gnt_i  in  N_SLAVES  slave grants.
- s_rvalid_i  in  N_SLAVES  slave response valids.
- s_rdata_i  in  N_SLAVES×32  packed slave read data.
- err_count_o  out  8  saturating count of error responses.

## Operation
- Decode is combinational on core_addr_i. The lowest-index matching slave wins. No match selects the error target.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: transaction granted by slave sel_q; waiting for its response.
  - ERR: error response pending.
- IDLE, mapped address:
  - s_req_o[sel] = core_req_i and core_gnt_o = s_gnt_i[sel]; all other bits are 0.
  - On core_req_i & s_gnt_i[sel]: sel_q ← sel and the timeout counter clears.
    - If s_rvalid_i[sel] is not also high that cycle, go to WAIT.
    - If it is high in the grant cycle, forward the response and stay in IDLE.
- IDLE, unmapped address with core_req_i: core_gnt_o = 1 the same cycle, s_req_o = 0, go to ERR.
- WAIT:
  - s_req_o = 0 and core_gnt_o = 0; no new request is accepted.
  - The counter increments each cycle.
  - On s_rvalid_i[sel_q]: core_rvalid_o = 1, core_rdata_o = s_rdata_i[sel_q], core_err_o = 0, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: core_rvalid_o = 1, core_err_o = 1, core_rdata_o = ERR_RDATA, go to IDLE.
- ERR: core_rvalid_o = 1, core_err_o = 1, core_rdata_o = ERR_RDATA, then go to IDLE.
- Stray rvalids are ignored and never reach the core. This covers rvalid in IDLE (outside a grant cycle) and rvalid from a non-selected slave. It also covers a late rvalid after a timeout.
- err_count_o increments on every error response (unmapped or timeout) and saturates at 255.
- Writes and reads are handled identically. The core receives rvalid for both.
- When core_rvalid_o = 0, core_rdata_o = 0 and core_err_o = 0.

## Timing
- Reset: FSM → IDLE, sel_q = 0, counter = 0, err_count_o = 0. In IDLE with core_req_i low: core_gnt_o = 0, core_rvalid_o = 0, core_err_o = 0, core_rdata_o = 0, s_req_o = 0.
- Combinational paths:
  - core_req_i → s_req_o
  - s_gnt_i → core_gnt_o
  - s_rvalid_i → core_rvalid_o and core_rdata_o
- No cycles are added on the forward path.
- Error latency: gnt in cycle N, error rvalid in cycle N+1.
- Timeout latency: gnt in cycle N, error rvalid in cycle N+TIMEOUT_CYCLES.
- Minimum turnaround: after a WAIT/ERR response in cycle M, the next grant is possible in cycle M+1.
- A slave with registered gnt and rvalid in the same cycle completes in that grant cycle and never enters WAIT.
- rst_i asserted in WAIT or ERR: the pending transaction is dropped and no rvalid is emitted.

## Test plan
- Read to 0x0000_0010: slave 0 gnt in cycle 1, rvalid with rdata 0x1234_5678 in cycle 3 → core_rvalid_o in cycle 3 with 0x1234_5678, core_err_o = 0.
- Write to 0x0010_0004 where slave 1 asserts gnt and rvalid in the same cycle → s_req_o = 2'b10, core_rvalid_o in the grant cycle, FSM stays in IDLE, a back-to-back second request is granted the next cycle.
- Read to 0x8000_0000 (unmapped) → core_gnt_o the same cycle, next cycle core_rvalid_o = 1, core_err_o = 1, rdata 0xDEAD_BEEF, err_count_o = 1.
- With TIMEOUT_CYCLES = 4, slave 0 grants and never responds → error rvalid exactly 4 cycles after the grant. A later stray s_rvalid_i[0] produces no core_rvalid_o.
- New core_req_i held high during WAIT → s_req_o = 0 and core_gnt_o = 0 until the response arrives, then it is granted the following cycle.
- rst_i pulsed for 1 cycle in WAIT → no core_rvalid_o, FSM in IDLE, err_count_o = 0. Also: 300 consecutive unmapped accesses → err_count_o saturates at 255.
